// File: rtl/wb_axis_pkg.sv
// Shared definitions for the Wishbone to AXI-Stream bridge: register map,
// STATUS bit layout, flush control bit and the bus handshake state encoding.
package wb_axis_pkg;

   localparam logic [7:0] REG_TX      = 8'h00;
   localparam logic [7:0] REG_RX      = 8'h04;
   localparam logic [7:0] REG_STATUS  = 8'h08;
   localparam logic [7:0] REG_TX_LAST = 8'h0C;

   localparam int unsigned ST_TX_FULL      = 0;
   localparam int unsigned ST_TX_EMPTY     = 1;
   localparam int unsigned ST_RX_FULL      = 2;
   localparam int unsigned ST_RX_EMPTY     = 3;
   localparam int unsigned ST_RX_HEAD_LAST = 4;
   localparam int unsigned ST_TX_COUNT_LSB = 8;
   localparam int unsigned ST_RX_COUNT_LSB = 16;

   localparam int unsigned FLUSH_BIT = 0;

   typedef enum logic [1:0] {
      WB_IDLE,
      WB_WAIT,
      WB_ACK
   } wb_state_e;

   typedef enum logic [2:0] {
      SEL_TX,
      SEL_RX,
      SEL_STATUS,
      SEL_TX_LAST,
      SEL_NONE
   } reg_sel_e;

   // Map a byte offset from the register base onto a register select.
   function automatic reg_sel_e decode_offset(input logic [7:0] off, input logic in_page);
      reg_sel_e sel;
      sel = SEL_NONE;
      if (in_page) begin
         case (off)
            REG_TX:      sel = SEL_TX;
            REG_RX:      sel = SEL_RX;
            REG_STATUS:  sel = SEL_STATUS;
            REG_TX_LAST: sel = SEL_TX_LAST;
            default:     sel = SEL_NONE;
         endcase
      end
      return sel;
   endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with show-ahead head, occupancy count and a flush that
// overrides any same-cycle push or pop.
module axis_sync_fifo #(
   parameter int unsigned WIDTH = 33,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Next pointer and occupancy values; flush wins over push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are only observed when the FIFO is non-empty.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/wb_axis_bridge.sv
// Wishbone slave exposing TX/RX stream FIFOs and a status/flush register.
module wb_axis_bridge
   import wb_axis_pkg::*;
#(
   parameter int unsigned             pDATA_WIDTH = 32,
   parameter logic [pDATA_WIDTH-1:0]  pBASE_ADDR  = 32'h3000_0080,
   parameter int unsigned             pTX_DEPTH   = 4,
   parameter int unsigned             pRX_DEPTH   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [pDATA_WIDTH-1:0]  wbs_adr_i,
   input  logic                    wb_valid,
   output logic                    wb_ready,
   input  logic                    wbs_we_i,
   input  logic [pDATA_WIDTH-1:0]  wbs_dat_i,
   output logic [pDATA_WIDTH-1:0]  wbs_dat_o,
   output logic                    sm_tvalid,
   input  logic                    sm_tready,
   output logic [pDATA_WIDTH-1:0]  sm_tdata,
   output logic                    sm_tlast,
   input  logic                    ss_tvalid,
   output logic                    ss_tready,
   input  logic [pDATA_WIDTH-1:0]  ss_tdata,
   input  logic                    ss_tlast
);

   localparam int unsigned TX_CW = $clog2(pTX_DEPTH) + 1;
   localparam int unsigned RX_CW = $clog2(pRX_DEPTH) + 1;

   wb_state_e               state_q, state_d;
   logic                    ready_q, ready_d;
   logic [pDATA_WIDTH-1:0]  dat_q, dat_d;
   logic [pDATA_WIDTH-1:0]  shadow_q, shadow_d;

   logic [pDATA_WIDTH-1:0]  offset;
   reg_sel_e                sel;
   logic                    res_rdy, go;
   logic                    tx_push, tx_pop, rx_push, rx_pop, flush;
   logic [pDATA_WIDTH:0]    tx_din, tx_dout, rx_dout;
   logic                    tx_full, tx_empty, rx_full, rx_empty;
   logic [TX_CW-1:0]        tx_count;
   logic [RX_CW-1:0]        rx_count;
   logic [31:0]             status;

   assign offset = wbs_adr_i - pBASE_ADDR;
   assign sel    = decode_offset(offset[7:0], offset[pDATA_WIDTH-1:8] == '0);

   // Stream side: empty FIFO heads are masked so outputs read 0 when idle.
   assign sm_tvalid = !tx_empty;
   assign sm_tdata  = tx_empty ? '0 : tx_dout[pDATA_WIDTH-1:0];
   assign sm_tlast  = !tx_empty && tx_dout[pDATA_WIDTH];
   assign tx_pop    = sm_tvalid && sm_tready;
   assign ss_tready = !rx_full && !rst;
   assign rx_push   = ss_tvalid && ss_tready;

   assign wb_ready  = ready_q;
   assign wbs_dat_o = dat_q;

   // STATUS register image.
   always_comb begin
      status                                = '0;
      status[ST_TX_FULL]                    = tx_full;
      status[ST_TX_EMPTY]                   = tx_empty;
      status[ST_RX_FULL]                    = rx_full;
      status[ST_RX_EMPTY]                   = rx_empty;
      status[ST_RX_HEAD_LAST]               = !rx_empty && rx_dout[pDATA_WIDTH];
      status[ST_TX_COUNT_LSB +: 8]          = 8'(tx_count);
      status[ST_RX_COUNT_LSB +: 8]          = 8'(rx_count);
   end

   // Bus handshake: stall on TX full / RX empty, commit side effects with the ack.
   always_comb begin
      res_rdy = 1'b1;
      if (wbs_we_i && (sel == SEL_TX || sel == SEL_TX_LAST)) res_rdy = !tx_full;
      else if (!wbs_we_i && sel == SEL_RX)                   res_rdy = !rx_empty;

      state_d = state_q;
      go      = 1'b0;
      case (state_q)
         WB_IDLE: begin
            if (wb_valid) begin
               if (res_rdy) begin
                  go      = 1'b1;
                  state_d = WB_ACK;
               end else begin
                  state_d = WB_WAIT;
               end
            end
         end
         WB_WAIT: begin
            if (!wb_valid) begin
               state_d = WB_IDLE;
            end else if (res_rdy) begin
               go      = 1'b1;
               state_d = WB_ACK;
            end
         end
         WB_ACK:  state_d = WB_IDLE;
         default: state_d = WB_IDLE;
      endcase

      tx_push  = go && wbs_we_i && (sel == SEL_TX || sel == SEL_TX_LAST);
      tx_din   = {sel == SEL_TX_LAST, wbs_dat_i};
      rx_pop   = go && !wbs_we_i && (sel == SEL_RX);
      flush    = go && wbs_we_i && (sel == SEL_STATUS) && wbs_dat_i[FLUSH_BIT];
      ready_d  = go;
      shadow_d = tx_push ? wbs_dat_i : shadow_q;

      dat_d = '0;
      if (go && !wbs_we_i) begin
         case (sel)
            SEL_TX:     dat_d = shadow_q;
            SEL_RX:     dat_d = rx_dout[pDATA_WIDTH-1:0];
            SEL_STATUS: dat_d = pDATA_WIDTH'(status);
            default:    dat_d = '0;
         endcase
      end
   end

   // Handshake state and registered bus outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= WB_IDLE;
         ready_q  <= 1'b0;
         dat_q    <= '0;
         shadow_q <= '0;
      end else begin
         state_q  <= state_d;
         ready_q  <= ready_d;
         dat_q    <= dat_d;
         shadow_q <= shadow_d;
      end
   end

   axis_sync_fifo #(
      .WIDTH (pDATA_WIDTH + 1),
      .DEPTH (pTX_DEPTH)
   ) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (tx_push),
      .din   (tx_din),
      .pop   (tx_pop),
      .dout  (tx_dout),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );

   axis_sync_fifo #(
      .WIDTH (pDATA_WIDTH + 1),
      .DEPTH (pRX_DEPTH)
   ) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (rx_push),
      .din   ({ss_tlast, ss_tdata}),
      .pop   (rx_pop),
      .dout  (rx_dout),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count)
   );

endmodule

// File: doc/wb_axis_bridge.md
# wb_axis_bridge

Parametrised Wishbone-to-AXI-Stream bridge between the user-project Wishbone decode and stream accelerators (FIR and successors). It buffers each direction in a FIFO, carries `tlast` both ways, exposes a status/control register, and stalls the Wishbone acknowledge on a full TX FIFO or an empty RX FIFO. Unmapped accesses are acknowledged, so the bus never hangs.

## Interface
- `pDATA_WIDTH`, 32, width of data, address and stream data
- `pBASE_ADDR`, 32'h3000_0080, byte address of register 0
- `pTX_DEPTH`, 4, TX FIFO depth (power of 2, 2..128)
- `pRX_DEPTH`, 4, RX FIFO depth (power of 2, 2..128)

- `clk` in 1 single clock, all logic on rising edge
- `rst` in 1 reset, synchronous, active-high
- `wbs_adr_i` in pDATA_WIDTH byte address
- `wb_valid` in 1 cyc&&stb&&address-in-window, from decode
- `wb_ready` out 1 one-cycle acknowledge
- `wbs_we_i` in 1 write enable
- `wbs_dat_i` in pDATA_WIDTH write data
- `wbs_dat_o` out pDATA_WIDTH read data, valid with wb_ready
- `sm_tvalid`/`sm_tready`/`sm_tdata`/`sm_tlast` out/in/out/out 1/1/pDATA_WIDTH/1, stream master to accelerator
- `ss_tvalid`/`ss_tready`/`ss_tdata`/`ss_tlast` in/out/in/in 1/1/pDATA_WIDTH/1, stream slave from accelerator

## Operation
- Register map (offset from pBASE_ADDR):
  - 0x0 TX: write pushes {tlast=0, data}; read returns last word written (shadow, 0 after reset).
  - 0x4 RX: read pops head, returns data; write ignored, acked.
  - 0x8 STATUS: read {8'h0, rx_count[7:0], tx_count[7:0], 3'b0, rx_head_last, rx_empty, rx_full, tx_empty, tx_full}. Write bit0=1 flushes both FIFOs; other bits ignored.
  - 0xC TX_LAST: write pushes {tlast=1, data}; read returns 0.
  - Any other address: ack in one cycle, read 0, write no effect.
- Wishbone FSM: IDLE, WAIT, ACK.
  - IDLE: wb_valid high and resource ready -> ACK (side effect applied on this edge); resource not ready -> WAIT. Resource = TX not full for TX/TX_LAST writes, RX not empty for RX reads; always ready otherwise.
  - WAIT: resource ready -> ACK with side effect; wb_valid low -> IDLE, no side effect.
  - ACK: wb_ready=1 for exactly one cycle -> IDLE; no request sampled in ACK.
- TX path: sm_tvalid = !tx_empty; sm_tdata/sm_tlast = head; pop on sm_tvalid&&sm_tready. Head stable while valid and not ready.
- RX path: ss_tready = !rx_full; push {ss_tlast, ss_tdata} on ss_tvalid&&ss_tready.
- Simultaneous push and pop on one FIFO: both happen, count unchanged. Push on full is impossible by construction (stall/ready gating).
- Flush: both FIFOs emptied on the write's edge; flush overrides any same-cycle stream push/pop; popped word, if any, is still consumed on the stream side.
- Counts are $clog2(depth)+1 bits, zero-extended into 8-bit fields.

## Timing
- Reset values: wb_ready 0, wbs_dat_o 0, sm_tvalid 0, sm_tdata 0, sm_tlast 0, ss_tready 0 while rst high, then 1 the cycle after rst deasserts; FSM IDLE; FIFOs empty.
- rst mid-transaction: in-flight access aborted, no ack, FIFO contents discarded.
- Unstalled access: request in cycle T, wb_ready and wbs_dat_o in T+1; peak throughput one access per 2 cycles.
- TX latency: write acked at T+1, sm_tvalid high at T+1 if FIFO was empty.
- RX latency: ss handshake at T, rx_empty low and a pending RX read acked at T+2.
- wbs_dat_o returns to 0 the cycle after ACK.

## Structure
- Package `wb_axis_pkg`: register offsets, STATUS bit positions, FSM state encoding, flush bit index.
- Sub-module `axis_sync_fifo` (params WIDTH, DEPTH; push/pop, full/empty/count, flush), instantiated twice with WIDTH=pDATA_WIDTH+1.

## Test plan
- Reset, write 0x11,0x22 to TX, 0x33 to TX_LAST, sm_tready=1 -> stream 0x11,0x22,0x33 with tlast only on 0x33; TX read returns 0x33.
- Depth 4, sm_tready=0, five TX writes -> fifth ack withheld; raise sm_tready -> fifth acked within 2 cycles, order preserved.
- RX read on empty FIFO, then inject ss_tdata=0xABCD tlast=1 -> ack 2 cycles later with 0xABCD; STATUS before pop shows rx_head_last=1.
- Fill RX to 4 -> ss_tready=0, STATUS rx_count=4 rx_full=1; one pop -> ss_tready=1 next cycle.
- Write STATUS bit0 with 3 words in each FIFO -> STATUS reads tx_empty=1 rx_empty=1, counts 0, sm_tvalid=0.
- Access pBASE_ADDR+0x10 read/write -> acked in 1 cycle, read 0; rst asserted during stalled write -> no ack, all outputs at reset values.
